voice_allocator: RTL and testbench

// - Polyphony scheduler in front of VOICES adsr envelope instances: accepts serialized note-on/off events
//   and drives each voice's gate and note number. Picks a voice by scanning per-voice state and LRU age.
// - Retriggers the adsr (gate low for one cycle) on reuse, so every assignment produces a gate edge.

---
 rtl/voice_allocator.sv | 252 +++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphony scheduler: serialized note-on/off events -> per-voice gate + note for VOICES adsr instances.
// Latency: gate changes VOICES+1 edges after accept (VOICES+2 for the retrigger/steal re-rise).
// Backpressure: ev_ready is high only in IDLE, so at most one event is in flight.
//
// Ports: clk, reset_n (async, active-low); ev_valid/ev_ready/ev_on/ev_note event input;
//        voice_active (adsr active flags); gate, voice_note (packed, voice v at [v*NOTE_BITS +: NOTE_BITS]);
//        ev_steal / ev_drop one-cycle status pulses.
// Build option: VOICE_STEAL_EN enables stealing the oldest gated voice when no other voice is available.
module voice_allocator #(
    parameter int VOICES    = 4,
    parameter int NOTE_BITS = 7
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_on,
    input  logic [NOTE_BITS-1:0]          ev_note,
    input  logic [VOICES-1:0]             voice_active,
    output logic [VOICES-1:0]             gate,
    output logic [VOICES*NOTE_BITS-1:0]   voice_note,
    output logic                          ev_steal,
    output logic                          ev_drop
);
    localparam int IW = $clog2(VOICES);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY, S_REGATE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_ev_ready;

    logic [IW-1:0]          r_scan_idx;
    logic                   r_ev_on;
    logic [NOTE_BITS-1:0]   r_ev_note;

    logic [VOICES-1:0]      r_gate;
    logic [NOTE_BITS-1:0]   r_note [VOICES];
    logic [IW-1:0]          r_rank [VOICES];
    logic [IW-1:0]          r_regate_idx;
    logic                   r_ev_drop;

    // Candidate accumulators built up one voice per scan cycle.
    logic                   r_match_vld;
    logic [IW-1:0]          r_match_idx;
    logic                   r_free_vld;
    logic [IW-1:0]          r_free_idx;
    logic                   r_rel_vld;
    logic [IW-1:0]          r_rel_idx;
    logic [IW-1:0]          r_rel_rank;

    logic                   w_accept;
    logic                   w_scan_last;
    logic                   w_cur_gate;
    logic                   w_cur_active;
    logic [NOTE_BITS-1:0]   w_cur_note;
    logic [IW-1:0]          w_cur_rank;

    logic                   w_sel_vld;
    logic [IW-1:0]          w_sel_idx;
    logic                   w_sel_regate;
    logic                   w_drop;

    assign w_accept     = ev_valid && r_ev_ready;
    assign w_scan_last  = (r_scan_idx == IW'(VOICES - 1));
    assign w_cur_gate   = r_gate[r_scan_idx];
    assign w_cur_active = voice_active[r_scan_idx];
    assign w_cur_note   = r_note[r_scan_idx];
    assign w_cur_rank   = r_rank[r_scan_idx];

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ev_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ev_ready <= (w_state_nxt == S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_SCAN;
            S_SCAN:   if (w_scan_last) w_state_nxt = S_APPLY;
            S_APPLY:  w_state_nxt = (w_sel_vld && w_sel_regate) ? S_REGATE : S_IDLE;
            S_REGATE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

`ifdef VOICE_STEAL_EN
    logic                   r_steal_vld;
    logic [IW-1:0]          r_steal_idx;
    logic [IW-1:0]          r_steal_rank;
    logic                   r_ev_steal;
    logic                   w_sel_steal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_steal_vld  <= 1'b0;
            r_steal_idx  <= '0;
            r_steal_rank <= '0;
            r_ev_steal   <= 1'b0;
        end else begin
            r_ev_steal <= 1'b0;
            if (r_state == S_IDLE && w_accept) begin
                r_steal_vld <= 1'b0;
            end else if (r_state == S_SCAN) begin
                if (w_cur_gate && (!r_steal_vld || w_cur_rank > r_steal_rank)) begin
                    r_steal_vld  <= 1'b1;
                    r_steal_idx  <= r_scan_idx;
                    r_steal_rank <= w_cur_rank;
                end
            end else if (r_state == S_APPLY) begin
                r_ev_steal <= w_sel_steal;
            end
        end
    end

    assign ev_steal = r_ev_steal;
`else
    assign ev_steal = 1'b0;
`endif

    // Voice choice, evaluated in APPLY from the completed scan.
    always_comb begin
        w_sel_vld    = 1'b0;
        w_sel_idx    = '0;
        w_sel_regate = 1'b0;
`ifdef VOICE_STEAL_EN
        w_sel_steal  = 1'b0;
`endif
        if (r_ev_on) begin
            if (r_match_vld) begin
                w_sel_vld    = 1'b1;
                w_sel_idx    = r_match_idx;
                w_sel_regate = 1'b1;
            end else if (r_free_vld) begin
                w_sel_vld = 1'b1;
                w_sel_idx = r_free_idx;
            end else if (r_rel_vld) begin
                w_sel_vld = 1'b1;
                w_sel_idx = r_rel_idx;
            end
`ifdef VOICE_STEAL_EN
            else if (r_steal_vld) begin
                w_sel_vld    = 1'b1;
                w_sel_idx    = r_steal_idx;
                w_sel_regate = 1'b1;
                w_sel_steal  = 1'b1;
            end
`endif
        end else if (r_match_vld) begin
            w_sel_vld = 1'b1;
            w_sel_idx = r_match_idx;
        end
    end

    // An unmatched note-off is silently ignored; only a note-on with no home is a drop.
    assign w_drop = r_ev_on && !w_sel_vld;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_idx   <= '0;
            r_ev_on      <= 1'b0;
            r_ev_note    <= '0;
            r_gate       <= '0;
            r_regate_idx <= '0;
            r_ev_drop    <= 1'b0;
            r_match_vld  <= 1'b0;
            r_match_idx  <= '0;
            r_free_vld   <= 1'b0;
            r_free_idx   <= '0;
            r_rel_vld    <= 1'b0;
            r_rel_idx    <= '0;
            r_rel_rank   <= '0;
            for (int v = 0; v < VOICES; v++) begin
                r_note[v] <= '0;
                r_rank[v] <= IW'(v);
            end
        end else begin
            r_ev_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ev_on     <= ev_on;
                        r_ev_note   <= ev_note;
                        r_scan_idx  <= '0;
                        r_match_vld <= 1'b0;
                        r_free_vld  <= 1'b0;
                        r_rel_vld   <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_scan_idx <= r_scan_idx + 1'b1;
                    if (!r_match_vld && w_cur_gate && w_cur_note == r_ev_note) begin
                        r_match_vld <= 1'b1;
                        r_match_idx <= r_scan_idx;
                    end
                    if (!r_free_vld && !w_cur_gate && !w_cur_active) begin
                        r_free_vld <= 1'b1;
                        r_free_idx <= r_scan_idx;
                    end
                    // Fully idle voices win over releasing ones anyway, so only
                    // releasing voices need tracking here.
                    if (!w_cur_gate && w_cur_active &&
                        (!r_rel_vld || w_cur_rank > r_rel_rank)) begin
                        r_rel_vld  <= 1'b1;
                        r_rel_idx  <= r_scan_idx;
                        r_rel_rank <= w_cur_rank;
                    end
                end
                S_APPLY: begin
                    r_ev_drop <= w_drop;
                    if (w_sel_vld) begin
                        r_regate_idx <= w_sel_idx;
                        if (r_ev_on) begin
                            r_note[w_sel_idx] <= r_ev_note;
                            r_gate[w_sel_idx] <= !w_sel_regate;
                            // Move the chosen voice to newest; everyone newer ages by one.
                            for (int v = 0; v < VOICES; v++) begin
                                if (IW'(v) == w_sel_idx)
                                    r_rank[v] <= '0;
                                else if (r_rank[v] < r_rank[w_sel_idx])
                                    r_rank[v] <= r_rank[v] + 1'b1;
                            end
                        end else begin
                            r_gate[w_sel_idx] <= 1'b0;
                        end
                    end
                end
                S_REGATE: begin
                    r_gate[r_regate_idx] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    assign ev_ready = r_ev_ready;
    assign gate     = r_gate;
    assign ev_drop  = r_ev_drop;

    for (genvar g = 0; g < VOICES; g++) begin : g_note_out
        assign voice_note[g*NOTE_BITS +: NOTE_BITS] = r_note[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (VOICES=4, NOTE_BITS=7).
// Events are driven on the falling edge; outputs are sampled 1 time unit after rising edges.
// Expected gates/notes are hand-derived from the allocation rules and the LRU rank history.
module tb_voice_allocator;
    localparam int VOICES = 4;
    localparam int NB     = 7;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NB-1:0]     ev_note;
    logic [VOICES-1:0] voice_active;
    logic [VOICES-1:0] gate;
    logic [VOICES*NB-1:0] voice_note;
    logic              ev_steal;
    logic              ev_drop;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    voice_allocator #(.VOICES(VOICES), .NOTE_BITS(NB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .voice_active (voice_active),
        .gate         (gate),
        .voice_note   (voice_note),
        .ev_steal     (ev_steal),
        .ev_drop      (ev_drop)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] note_of(input int v);
        return voice_note[v*NB +: NB];
    endfunction

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one event; returns 1 unit after the accepting edge E0.
    task automatic send(input logic on, input logic [NB-1:0] note);
        int t = 0;
        @(negedge clk);
        while (!ev_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk_eq("ready_before_event", ev_ready, 1);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = note;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
    endtask

    // Event whose effect is a single gate change (or none) at E5.
    task automatic do_ev(input string tag, input logic on, input logic [NB-1:0] note,
                         input logic [3:0] pre, input logic [3:0] post,
                         input int v, input logic [NB-1:0] vnote);
        send(on, note);
        chk_eq({tag, "_busy"}, ev_ready, 0);
        edges(4);
        chk_eq({tag, "_gate_E4"}, gate, pre);
        edges(1);
        chk_eq({tag, "_gate_E5"}, gate, post);
        chk_eq({tag, "_note"}, note_of(v), vnote);
        chk_eq({tag, "_drop"}, ev_drop, 0);
        chk_eq({tag, "_steal"}, ev_steal, 0);
        chk_eq({tag, "_ready_E5"}, ev_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        ev_valid     = 1'b0;
        ev_on        = 1'b0;
        ev_note      = '0;
        voice_active = '0;
        edges(2);
        chk_eq("rst_gate", gate, 0);
        chk_eq("rst_notes", voice_note, 0);
        chk_eq("rst_ready", ev_ready, 1);
        chk_eq("rst_steal", ev_steal, 0);
        chk_eq("rst_drop", ev_drop, 0);
        @(negedge clk) reset_n = 1'b1;

        // Fill voices 0..2 from idle.
        do_ev("on60", 1'b1, 7'd60, 4'b0000, 4'b0001, 0, 7'd60);
        do_ev("on62", 1'b1, 7'd62, 4'b0001, 4'b0011, 1, 7'd62);
        do_ev("on64", 1'b1, 7'd64, 4'b0011, 4'b0111, 2, 7'd64);
        chk_eq("fill_note0", note_of(0), 60);
        chk_eq("fill_note1", note_of(1), 62);

        // Note-off keeps pitch; unknown note-off is ignored without a drop.
        do_ev("off62", 1'b0, 7'd62, 4'b0111, 4'b0101, 1, 7'd62);
        do_ev("off70", 1'b0, 7'd70, 4'b0101, 4'b0101, 1, 7'd62);

        // Retrigger of a gated note: low for exactly one cycle.
        send(1'b1, 7'd60);
        edges(4);
        chk_eq("retrig_gate_E4", gate, 4'b0101);
        edges(1);
        chk_eq("retrig_gate_E5", gate, 4'b0100);
        chk_eq("retrig_note0", note_of(0), 60);
        chk_eq("retrig_ready_E5", ev_ready, 0);
        edges(1);
        chk_eq("retrig_gate_E6", gate, 4'b0101);
        chk_eq("retrig_ready_E6", ev_ready, 1);
        edges(1);
        chk_eq("retrig_gate_E7", gate, 4'b0101);
        // ranks now v0=0 v1=2 v2=1 v3=3

        // Idle voice 3 preferred over releasing voice 1.
        voice_active = 4'b0111;
        do_ev("on67_idle", 1'b1, 7'd67, 4'b0101, 4'b1101, 3, 7'd67);
        // ranks v0=1 v1=3 v2=2 v3=0
        do_ev("off67", 1'b0, 7'd67, 4'b1101, 4'b0101, 3, 7'd67);
        voice_active = 4'b1111;
        // Both 1 and 3 releasing: oldest (voice 1, rank 3) wins.
        do_ev("on71_rel", 1'b1, 7'd71, 4'b0101, 4'b0111, 1, 7'd71);
        // ranks v0=2 v1=0 v2=3 v3=1
        do_ev("off71", 1'b0, 7'd71, 4'b0111, 4'b0101, 1, 7'd71);
        // Now voice 3 (rank 1) is older than voice 1 (rank 0).
        do_ev("on72_rel", 1'b1, 7'd72, 4'b0101, 4'b1101, 3, 7'd72);

        // Reset in the middle of a scan abandons the event.
        send(1'b1, 7'd80);
        edges(2);
        chk_eq("midscan_busy", ev_ready, 0);
        reset_n = 1'b0;
        #1;
        chk_eq("midscan_rst_gate", gate, 0);
        chk_eq("midscan_rst_notes", voice_note, 0);
        chk_eq("midscan_rst_ready", ev_ready, 1);
        @(negedge clk) reset_n = 1'b1;
        edges(8);
        chk_eq("midscan_abandoned", gate, 0);

        // Fill all four voices, then one more note-on.
        voice_active = 4'b0000;
        do_ev("s_on60", 1'b1, 7'd60, 4'b0000, 4'b0001, 0, 7'd60);
        do_ev("s_on62", 1'b1, 7'd62, 4'b0001, 4'b0011, 1, 7'd62);
        do_ev("s_on64", 1'b1, 7'd64, 4'b0011, 4'b0111, 2, 7'd64);
        do_ev("s_on65", 1'b1, 7'd65, 4'b0111, 4'b1111, 3, 7'd65);
        voice_active = 4'b1111;
        send(1'b1, 7'd67);
        edges(4);
        chk_eq("full_gate_E4", gate, 4'b1111);
        edges(1);
`ifdef VOICE_STEAL_EN
        chk_eq("steal_gate_E5", gate, 4'b1110);
        chk_eq("steal_note0", note_of(0), 67);
        chk_eq("steal_pulse", ev_steal, 1);
        chk_eq("steal_nodrop", ev_drop, 0);
        edges(1);
        chk_eq("steal_gate_E6", gate, 4'b1111);
        chk_eq("steal_pulse_end", ev_steal, 0);
`else
        chk_eq("drop_gate_E5", gate, 4'b1111);
        chk_eq("drop_pulse", ev_drop, 1);
        chk_eq("drop_nosteal", ev_steal, 0);
        chk_eq("drop_note0", note_of(0), 60);
        chk_eq("drop_note3", note_of(3), 65);
        edges(1);
        chk_eq("drop_pulse_end", ev_drop, 0);
        chk_eq("drop_ready", ev_ready, 1);
        chk_eq("drop_gate_E6", gate, 4'b1111);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
